// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch core: run-state enum,
// active-low 7-segment patterns ({g,f,e,d,c,b,a}) and the BCD digit width.
package stopwatch_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } sw_state_e;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD nibble to active-low 7-segment pattern; A-F decode blank.
module bcd_seg_decode
  import stopwatch_pkg::*;
(
  input  logic [BCD_W-1:0] nibble_i,
  output logic [6:0]       seg_n_o
);

  always_comb begin
    case (nibble_i)
      4'd0:    seg_n_o = SEG_0;
      4'd1:    seg_n_o = SEG_1;
      4'd2:    seg_n_o = SEG_2;
      4'd3:    seg_n_o = SEG_3;
      4'd4:    seg_n_o = SEG_4;
      4'd5:    seg_n_o = SEG_5;
      4'd6:    seg_n_o = SEG_6;
      4'd7:    seg_n_o = SEG_7;
      4'd8:    seg_n_o = SEG_8;
      4'd9:    seg_n_o = SEG_9;
      default: seg_n_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_stopwatch_core.sv
// N-digit BCD stopwatch: synchronised buttons, run-state FSM, prescaled count,
// timed lap hold and multiplexed 7-segment scan. Option: STOPWATCH_ZERO_BLANK_EN.
module bcd_stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned TICK_DIV     = 1200000,
  parameter int unsigned LAP_HOLD     = 20,
  parameter int unsigned REFRESH_BITS = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      btn_clear,
  input  logic                      btn_start,
  input  logic                      btn_stop,
  input  logic                      btn_lap,
  output logic [BCD_W*DIGITS-1:0]   count_bcd,
  output logic [6:0]                seg_n,
  output logic [DIGITS-1:0]         digit_sel,
  output logic                      running,
  output logic                      lap_active,
  output logic                      overflow
);

  localparam int unsigned CW = BCD_W * DIGITS;
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned IW = $clog2(DIGITS);

  // Button order in the vectors below: {lap, stop, start, clear}
  logic [3:0] btn_raw;
  logic [3:0] sync1_q, sync2_q, prev_q;
  logic [3:0] pulse;
  logic       clr_p, start_p, stop_p, lap_p;

  logic [PW-1:0]           presc_q, presc_d;
  logic                    tick;

  sw_state_e               state_q, state_d;
  logic                    cnt_en, lap_take;

  logic [CW-1:0]           count_q, count_d, count_inc;
  logic                    inc_carry;
  logic                    ovf_q, ovf_d;
  logic [CW-1:0]           lap_q, lap_d;
  logic [7:0]              timer_q, timer_d;

  logic [REFRESH_BITS-1:0] refresh_q;
  logic                    scan_step;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           disp;
  logic [BCD_W-1:0]        nibble;
  logic [6:0]              dec_seg;
  logic                    blank;
  logic [6:0]              seg_q, seg_d;
  logic [DIGITS-1:0]       dsel_q, dsel_d;

  assign btn_raw = {btn_lap, btn_stop, btn_start, btn_clear};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse   = sync2_q & ~prev_q;
  assign clr_p   = pulse[0];
  assign start_p = pulse[1];
  assign stop_p  = pulse[2];
  assign lap_p   = pulse[3];

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A higher-priority pulse masks lower ones even when it has no effect itself.
  always_comb begin
    state_d = state_q;
    if (clr_p) begin
      state_d = IDLE;
    end else if (stop_p) begin
      if (state_q == RUN) state_d = HOLD;
    end else if (start_p) begin
      if (state_q != RUN) state_d = RUN;
    end
  end

  always_comb begin
    running  = (state_q == RUN);
    cnt_en   = tick && (state_q == RUN) && !clr_p;
    lap_take = lap_p && !clr_p && !stop_p && !start_p && (state_q == RUN);
  end

  always_comb begin
    count_inc = count_q;
    inc_carry = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (inc_carry) begin
        if (count_q[i*BCD_W +: BCD_W] == 4'd9) begin
          count_inc[i*BCD_W +: BCD_W] = '0;
        end else begin
          count_inc[i*BCD_W +: BCD_W] = count_q[i*BCD_W +: BCD_W] + 1'b1;
          inc_carry = 1'b0;
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    lap_d   = lap_q;
    timer_d = timer_q;
    if (clr_p) begin
      count_d = '0;
      ovf_d   = 1'b0;
      timer_d = '0;
    end else begin
      if (cnt_en) begin
        count_d = count_inc;
        if (inc_carry) ovf_d = 1'b1;
      end
      if (lap_take) begin
        lap_d   = count_q;
        timer_d = 8'(LAP_HOLD);
      end else if (tick && timer_q != '0) begin
        timer_d = timer_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      lap_q   <= '0;
      timer_q <= '0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      lap_q   <= lap_d;
      timer_q <= timer_d;
    end
  end

  assign count_bcd  = count_q;
  assign overflow   = ovf_q;
  assign lap_active = (timer_q != '0);

  assign disp      = lap_active ? lap_q : count_q;
  assign scan_step = &refresh_q;

  always_comb begin
    idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
  end

  always_comb begin
    nibble = '0;
    dsel_d = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nibble    = disp[i*BCD_W +: BCD_W];
        dsel_d[i] = 1'b1;
      end
    end
  end

`ifdef STOPWATCH_ZERO_BLANK_EN
  logic [DIGITS-1:0] lead_zero;
  logic              above_zero;

  // lead_zero[i]: digit i and every digit above it are zero.
  always_comb begin
    lead_zero  = '0;
    above_zero = 1'b1;
    blank      = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      above_zero = above_zero && (disp[(DIGITS-1-k)*BCD_W +: BCD_W] == '0);
      lead_zero[DIGITS-1-k] = above_zero;
    end
    for (int unsigned i = 1; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) blank = lead_zero[i];
    end
  end
`else
  assign blank = 1'b0;
`endif

  bcd_seg_decode u_dec (
    .nibble_i (nibble),
    .seg_n_o  (dec_seg)
  );

  assign seg_d = blank ? SEG_BLANK : dec_seg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_q <= '0;
      idx_q     <= '0;
      seg_q     <= SEG_BLANK;
      dsel_q    <= '0;
    end else begin
      refresh_q <= refresh_q + 1'b1;
      if (scan_step) begin
        idx_q  <= idx_d;
        seg_q  <= seg_d;
        dsel_q <= dsel_d;
      end
    end
  end

  assign seg_n     = seg_q;
  assign digit_sel = dsel_q;

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// Scoreboard bench for bcd_stopwatch_core (DIGITS=4, TICK_DIV=4, LAP_HOLD=3,
// REFRESH_BITS=2). Cycle k is counted from the final reset release.
module tb_bcd_stopwatch_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_clear, btn_start, btn_stop, btn_lap;
  logic [15:0] count_bcd;
  logic [6:0]  seg_n;
  logic [3:0]  digit_sel;
  logic        running, lap_active, overflow;

  localparam logic [3:0] B_CLR = 4'b0001;
  localparam logic [3:0] B_STA = 4'b0010;
  localparam logic [3:0] B_STP = 4'b0100;
  localparam logic [3:0] B_LAP = 4'b1000;

  localparam logic [6:0] P0 = 7'h40, P1 = 7'h79, P2 = 7'h24, P5 = 7'h12;
  localparam logic [6:0] P7 = 7'h78, PB = 7'h7F;
`ifdef STOPWATCH_ZERO_BLANK_EN
  localparam logic [6:0] LEAD = 7'h7F;
`else
  localparam logic [6:0] LEAD = 7'h40;
`endif

  bcd_stopwatch_core #(
    .DIGITS       (4),
    .TICK_DIV     (4),
    .LAP_HOLD     (3),
    .REFRESH_BITS (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_clear  (btn_clear),
    .btn_start  (btn_start),
    .btn_stop   (btn_stop),
    .btn_lap    (btn_lap),
    .count_bcd  (count_bcd),
    .seg_n      (seg_n),
    .digit_sel  (digit_sel),
    .running    (running),
    .lap_active (lap_active),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef enum int {S_COUNT, S_SEG, S_DSEL, S_RUN, S_LAP, S_OVF} sig_e;
  typedef struct {
    string       name;
    sig_e        sel;
    logic [31:0] exp;
  } item_t;

  item_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    base     = 0;
  bit    done     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pick(input sig_e s);
    case (s)
      S_COUNT: return {16'd0, count_bcd};
      S_SEG:   return {25'd0, seg_n};
      S_DSEL:  return {28'd0, digit_sel};
      S_RUN:   return {31'd0, running};
      S_LAP:   return {31'd0, lap_active};
      default: return {31'd0, overflow};
    endcase
  endfunction

  // Monitor: everything queued since the last negedge is checked here.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      item_t       it;
      logic [31:0] act;
      it  = exp_q.pop_front();
      act = pick(it.sel);
      checks++;
      if (act !== it.exp) begin
        failures++;
        $display("FAIL %s: got %0h expected %0h", it.name, act, it.exp);
      end
    end
  end

  initial begin
    #2000000;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL watchdog: simulation did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic expect_v(input string n, input sig_e s, input logic [31:0] v);
    item_t it;
    it.name = n;
    it.sel  = s;
    it.exp  = v;
    exp_q.push_back(it);
  endtask

  task automatic press(input logic [3:0] m);
    {btn_lap, btn_stop, btn_start, btn_clear} = m;
    @(posedge clk); #1;
    {btn_lap, btn_stop, btn_start, btn_clear} = '0;
  endtask

  task automatic goto(input int n);
    checks++;
    if (cyc > base + n) begin
      failures++;
      $display("FAIL wait_expired: target %0d already passed (now %0d)", n, cyc - base);
    end
    while (cyc < base + n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_reset(input string tag);
    expect_v({tag, "_count"}, S_COUNT, 32'h0);
    expect_v({tag, "_seg"},   S_SEG,   32'h7F);
    expect_v({tag, "_dsel"},  S_DSEL,  32'h0);
    expect_v({tag, "_run"},   S_RUN,   32'h0);
    expect_v({tag, "_lap"},   S_LAP,   32'h0);
    expect_v({tag, "_ovf"},   S_OVF,   32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    {btn_lap, btn_stop, btn_start, btn_clear} = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    press(B_STA);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (count_bcd !== 16'h0 || seg_n !== 7'h7F || digit_sel !== 4'h0 ||
        running !== 1'b0 || lap_active !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_state: cnt=%0h seg=%0h dsel=%0h run=%0b lap=%0b ovf=%0b",
               count_bcd, seg_n, digit_sel, running, lap_active, overflow);
    end
    expect_reset("midrun_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    base  = cyc;

    expect_reset("rel_rst");
    press(B_STA);
    goto(4);
    expect_v("first_dsel", S_DSEL, 32'h1);
    expect_v("first_seg", S_SEG, {25'd0, P0});
    expect_v("start_run", S_RUN, 32'h1);
    expect_v("first_tick", S_COUNT, 32'h0001);

    goto(40);
    expect_v("cnt_10", S_COUNT, 32'h0010);
    expect_v("run_10", S_RUN, 32'h1);
    press(B_STP);
    goto(48);
    expect_v("stop_frozen", S_COUNT, 32'h0010);
    expect_v("stop_run", S_RUN, 32'h0);
    press(B_STA);

    goto(40004);
    expect_v("cnt_9999", S_COUNT, 32'h9999);
    expect_v("ovf_pre", S_OVF, 32'h0);
    goto(40008);
    expect_v("wrap_cnt", S_COUNT, 32'h0000);
    expect_v("wrap_ovf", S_OVF, 32'h1);
    expect_v("wrap_run", S_RUN, 32'h1);
    press(B_CLR);
    goto(40012);
    expect_v("clr_cnt", S_COUNT, 32'h0);
    expect_v("clr_ovf", S_OVF, 32'h0);
    expect_v("clr_run", S_RUN, 32'h0);

    goto(40024);
    press(B_STA);
    goto(40123);
    press(B_LAP);
    goto(40126);
    expect_v("lap_on", S_LAP, 32'h1);
    expect_v("lap_cnt25", S_COUNT, 32'h0025);
    goto(40132);
    expect_v("lap_hold", S_LAP, 32'h1);
    expect_v("lap_live27", S_COUNT, 32'h0027);
    expect_v("lap_d0_sel", S_DSEL, 32'h1);
    expect_v("lap_d0_seg", S_SEG, {25'd0, P5});
    goto(40136);
    expect_v("lap_off", S_LAP, 32'h0);
    expect_v("lap_live28", S_COUNT, 32'h0028);
    expect_v("lap_d1_sel", S_DSEL, 32'h2);
    expect_v("lap_d1_seg", S_SEG, {25'd0, P2});
    goto(40148);
    expect_v("live_d0_sel", S_DSEL, 32'h1);
    expect_v("live_d0_seg", S_SEG, {25'd0, P0});
    press(B_STP);
    goto(40152);
    press(B_LAP);
    goto(40156);
    expect_v("hold_lap_ign", S_LAP, 32'h0);
    expect_v("hold_run", S_RUN, 32'h0);
    expect_v("hold_cnt", S_COUNT, 32'h0031);

    press(B_CLR | B_STA);
    goto(40160);
    expect_v("clrsta_run", S_RUN, 32'h0);
    expect_v("clrsta_cnt", S_COUNT, 32'h0);
    goto(40164);
    expect_v("idle_cnt", S_COUNT, 32'h0);
    press(B_STA);
    goto(40168);
    expect_v("restart_run", S_RUN, 32'h1);
    expect_v("restart_cnt", S_COUNT, 32'h0001);
    press(B_STP | B_STA);
    goto(40176);
    expect_v("stpsta_run", S_RUN, 32'h0);
    expect_v("stpsta_cnt", S_COUNT, 32'h0001);

    press(B_CLR);
    goto(40180);
    expect_v("clr2_cnt", S_COUNT, 32'h0);
    press(B_STA);
    goto(40208);
    expect_v("cnt_7", S_COUNT, 32'h0007);
    press(B_STP);
    goto(40212);
    expect_v("zb_d0_sel", S_DSEL, 32'h1);
    expect_v("zb_d0_seg", S_SEG, {25'd0, P7});
    goto(40216);
    expect_v("zb_d1_sel", S_DSEL, 32'h2);
    expect_v("zb_d1_seg", S_SEG, {25'd0, LEAD});
    goto(40220);
    expect_v("zb_d2_sel", S_DSEL, 32'h4);
    expect_v("zb_d2_seg", S_SEG, {25'd0, LEAD});
    goto(40224);
    expect_v("zb_d3_sel", S_DSEL, 32'h8);
    expect_v("zb_d3_seg", S_SEG, {25'd0, LEAD});
    expect_v("zb_cnt", S_COUNT, 32'h0007);
    expect_v("zb_not_blank_all", S_SEG, {25'd0, (LEAD == PB) ? PB : P0});

    goto(40228);
    @(negedge clk);
    @(negedge clk);
    #1;
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
